mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Round-robin arbiter sharing the data-side port of the unified 256KB memory
// (read port 1 + byte-enable write port) between two requesters: m0 = CPU
// data stage, m1 = DMA/debug loader. Grants at most one access per enabled
// cycle, drives the memory address/write lines combinationally, and tracks
// the memory's fixed 2-cycle read latency to route read data to its owner.
// PARAMETERS
// ADDR_W      18  byte address width (word index = addr[ADDR_W-1:2])
// DATA_W      32  data width; byte enables are DATA_W/8 bits
// RD_LATENCY  2   enabled clock edges from read grant to valid mem_rdata
// PORTS
// clk        in   1         system clock, all state on posedge
// rst_n      in   1         asynchronous active-low reset
// clk_en     in   1         global stall enable, shared with memory; 0 = freeze
// m0_req     in   1         m0 access request; hold req/we/addr/wdata until gnt
// m0_we      in   4         m0 byte write enables; 4'b0000 = read
// m0_addr    in   ADDR_W    m0 byte address
// m0_wdata   in   DATA_W    m0 write data
// m0_gnt     out  1         m0 access issued this cycle (combinational)
// m0_rvalid  out  1         m0 read data valid on m0_rdata (registered)
// m0_rdata   out  DATA_W    m0 read data
// m1_*       (same seven ports as m0_*, for requester 1)
// mem_raddr  out  ADDR_W    to memory raddr1
// mem_wen    out  4         to memory wen
// mem_waddr  out  ADDR_W    to memory waddr
// mem_wdata  out  DATA_W    to memory wdata
// mem_rdata  in   DATA_W    from memory rdata1
// BEHAVIOUR
// - Reset (async, rst_n=0): last_gnt<=1 (m0 wins first tie), read pipe valid
//   bits<=0, m0_rvalid=m1_rvalid=0. In-flight reads are dropped, never returned.
// - Grant (comb): clk_en=0 -> no gnt, mem_wen=0. Else only one req -> grant it;
//   both -> grant the requester != last_gnt. last_gnt updates on enabled edge.
// - Granted access drives mem_raddr=mem_waddr=addr, mem_wdata=wdata,
//   mem_wen=we. No grant: mem_wen=0, addresses/wdata=0.
// - Granted read (we==0): push {valid=1, owner} into RD_LATENCY-deep shift
//   pipe. Pipe shifts only on edges with clk_en=1; pipe input is 0 when no read
//   granted. Writes occupy the slot but push valid=0.
// - mX_rvalid = pipe[RD_LATENCY-1].valid && owner==X; both rdata outputs =
//   mem_rdata. Read granted in enabled cycle t -> rvalid high in cycle t+2
//   (no stall); each stalled cycle adds one. rvalid/rdata hold stable while
//   clk_en=0; requester consumes on the next enabled edge.
// - Throughput: one access/enabled cycle; back-to-back reads fully pipelined;
//   worst-case wait under contention = 1 grant (strict alternation).
// - Ordering: responses return in grant order. Read granted the cycle after
//   a write to the same word returns new data; arbiter adds no forwarding.
// - Requester dropping req before gnt is legal (request withdrawn); changing
//   addr/we while req high and not granted is illegal.
// - Addresses pass unmodified; low 2 bits ignored by memory (word aligned).
// TESTING
// 1 Reset: rst_n=0 mid-read (pipe valid) -> rvalid both 0 next cycle, no
//   response after release; first tie after reset grants m0.
// 2 Solo read: m0 reads 0x00010 (mem word 4 = 0xDEADBEEF) at t -> m0_gnt at t,
//   m0_rvalid=1, m0_rdata=0xDEADBEEF at t+2, m1_rvalid=0.
// 3 Contention: m0,m1 req continuously, reads -> gnts alternate m0,m1,m0,...;
//   rvalid alternates owners 2 cycles later, data matches each address.
// 4 Byte write: m1 we=4'b0010, addr 0x00100, wdata 0x0000AB00 -> mem_wen=0010;
//   subsequent m0 read of 0x00100 returns byte[15:8]=0xAB, others unchanged.
// 5 Stall: read granted at t, clk_en=0 for 3 cycles at t+1 -> no gnt during
//   stall, rvalid rises at t+5 and holds until next enabled edge.
// 6 Write-read: m0 write 0x12345678 to 0x00200 at t, m1 read 0x00200 at t+1
//   -> m1_rdata=0x12345678 at t+3.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared data-side memory port. It tracks the fixed
// memory read latency so that each read response is steered back to its owner.
module mem_port_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,

    input  logic                m0_req,
    input  logic [DATA_W/8-1:0] m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_req,
    input  logic [DATA_W/8-1:0] m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic [ADDR_W-1:0]   mem_raddr,
    output logic [DATA_W/8-1:0] mem_wen,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_slot_t;

    owner_t   last_gnt;
    rd_slot_t rd_pipe [RD_LATENCY];
    rd_slot_t rd_in;
    logic     gnt0;
    logic     gnt1;

    // On a tie, the requester that was not granted last time wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (clk_en) begin
            if (m0_req && m1_req) begin
                if (last_gnt == OWN_M0) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else if (m0_req) begin
                gnt0 = 1'b1;
            end else if (m1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    always_comb begin
        mem_raddr = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_wen   = '0;
        if (gnt0) begin
            mem_raddr = m0_addr;
            mem_waddr = m0_addr;
            mem_wdata = m0_wdata;
            mem_wen   = m0_we;
        end else if (gnt1) begin
            mem_raddr = m1_addr;
            mem_waddr = m1_addr;
            mem_wdata = m1_wdata;
            mem_wen   = m1_we;
        end
    end

    // A write still takes a pipe slot, but it pushes valid=0.
    always_comb begin
        rd_in.valid = (gnt0 && (m0_we == '0)) || (gnt1 && (m1_we == '0));
        rd_in.owner = gnt1 ? OWN_M1 : OWN_M0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= OWN_M1;
        end else if (clk_en && (gnt0 || gnt1)) begin
            last_gnt <= gnt1 ? OWN_M1 : OWN_M0;
        end
    end

    // The pipe advances only on enabled edges, so a stall delays the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= '{valid: 1'b0, owner: OWN_M0};
            end
        end else if (clk_en) begin
            rd_pipe[0] <= rd_in;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign m0_rvalid = rd_pipe[RD_LATENCY-1].valid && (rd_pipe[RD_LATENCY-1].owner == OWN_M0);
    assign m1_rvalid = rd_pipe[RD_LATENCY-1].valid && (rd_pipe[RD_LATENCY-1].owner == OWN_M1);
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. It uses a behavioural 2-cycle memory,
// and the expected read responses are hand-computed constants.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        m0_req, m1_req;
    logic [3:0]  m0_we, m1_we;
    logic [17:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [17:0] mem_raddr, mem_waddr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        int unsigned due;
    } exp_t;
    exp_t sb[$];

    mem_port_arbiter #(.ADDR_W(18), .DATA_W(32), .RD_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_raddr(mem_raddr), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory with a registered address and registered data, frozen while clk_en=0.
    logic [31:0] mem [1024];
    logic [17:0] raddr_q = '0;
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | i;
        mem[4] = 32'hDEAD_BEEF;
    end
    always @(posedge clk) begin
        if (clk_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wen[b]) mem[mem_waddr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            raddr_q   <= mem_raddr;
            mem_rdata <= mem[raddr_q[11:2]];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic owner, input logic [31:0] data, input int unsigned due);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        e.due   = due;
        sb.push_back(e);
    endtask

    // Response monitor: a response is consumed on an enabled edge.
    always @(negedge clk) begin
        if (rst_n && clk_en && (m0_rvalid || m1_rvalid)) begin
            if (m0_rvalid && m1_rvalid) begin
                n_checks++;
                n_fail++;
                $display("FAIL rvalid_onehot: got both rvalid high expected one (cycle %0d)", cyc);
            end else if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rvalid m0=%0b m1=%0b expected none (cycle %0d)",
                         m0_rvalid, m1_rvalid, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_owner", {63'd0, m1_rvalid}, {63'd0, e.owner});
                check("rsp_data", {32'd0, (m1_rvalid ? m1_rdata : m0_rdata)}, {32'd0, e.data});
                check("rsp_cycle", {32'd0, cyc}, {32'd0, e.due});
            end
        end
    end

    task automatic set_m0(input logic req, input logic [3:0] we, input logic [17:0] addr,
                          input logic [31:0] wdata);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic set_m1(input logic req, input logic [3:0] we, input logic [17:0] addr,
                          input logic [31:0] wdata);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input logic g0, input logic g1, input logic [17:0] addr,
                                input logic [3:0] wen, input logic [31:0] wdata);
        @(negedge clk);
        check("m0_gnt", {63'd0, m0_gnt}, {63'd0, g0});
        check("m1_gnt", {63'd0, m1_gnt}, {63'd0, g1});
        check("mem_raddr", {46'd0, mem_raddr}, {46'd0, addr});
        check("mem_waddr", {46'd0, mem_waddr}, {46'd0, addr});
        check("mem_wen", {60'd0, mem_wen}, {60'd0, wen});
        check("mem_wdata", {32'd0, mem_wdata}, {32'd0, wdata});
    endtask

    task automatic step(input logic g0, input logic g1, input logic [17:0] addr,
                        input logic [3:0] wen, input logic [31:0] wdata);
        expect_cycle(g0, g1, addr, wen, wdata);
        next_cycle();
    endtask

    task automatic idle(input int n);
        set_m0(1'b0, 4'h0, '0, '0);
        set_m1(1'b0, 4'h0, '0, '0);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 4'h0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [17:0] a0 [4];
        logic [17:0] a1 [4];
        logic [31:0] d0 [4];
        logic [31:0] d1 [4];
        int i0, i1;
        int unsigned t;

        a0[0] = 18'h00020; a0[1] = 18'h00024; a0[2] = 18'h00028; a0[3] = 18'h0002C;
        a1[0] = 18'h00040; a1[1] = 18'h00044; a1[2] = 18'h00048; a1[3] = 18'h0004C;
        d0[0] = 32'h1000_0008; d0[1] = 32'h1000_0009; d0[2] = 32'h1000_000A; d0[3] = 32'h1000_000B;
        d1[0] = 32'h1000_0010; d1[1] = 32'h1000_0011; d1[2] = 32'h1000_0012; d1[3] = 32'h1000_0013;

        rst_n  = 1'b0;
        clk_en = 1'b1;
        set_m0(1'b0, 4'h0, '0, '0);
        set_m1(1'b0, 4'h0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        check("reset_m0_rvalid", {63'd0, m0_rvalid}, 64'd0);
        check("reset_m1_rvalid", {63'd0, m1_rvalid}, 64'd0);
        check("reset_mem_wen", {60'd0, mem_wen}, 64'd0);
        next_cycle();

        // Reset while a read is in flight: the response must be dropped.
        set_m0(1'b1, 4'h0, 18'h00010, '0);
        step(1'b1, 1'b0, 18'h00010, 4'h0, '0);
        set_m0(1'b0, 4'h0, '0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_m0_rvalid", {63'd0, m0_rvalid}, 64'd0);
        check("rst_mid_m1_rvalid", {63'd0, m1_rvalid}, 64'd0);
        next_cycle();
        rst_n = 1'b1;
        idle(4);

        // Contention: the first tie after reset goes to m0, then grants alternate.
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 6; k++) begin
            set_m0(1'b1, 4'h0, a0[i0], '0);
            set_m1(1'b1, 4'h0, a1[i1], '0);
            if (k % 2 == 0) begin
                push(1'b0, d0[i0], cyc + 2);
                expect_cycle(1'b1, 1'b0, a0[i0], 4'h0, '0);
                i0++;
            end else begin
                push(1'b1, d1[i1], cyc + 2);
                expect_cycle(1'b0, 1'b1, a1[i1], 4'h0, '0);
                i1++;
            end
            next_cycle();
        end
        idle(3);

        // Solo read of word 4.
        set_m0(1'b1, 4'h0, 18'h00010, '0);
        push(1'b0, 32'hDEAD_BEEF, cyc + 2);
        step(1'b1, 1'b0, 18'h00010, 4'h0, '0);
        idle(3);

        // Byte write from m1, then a read-back from m0.
        set_m1(1'b1, 4'b0010, 18'h00100, 32'h0000_AB00);
        step(1'b0, 1'b1, 18'h00100, 4'b0010, 32'h0000_AB00);
        set_m1(1'b0, 4'h0, '0, '0);
        set_m0(1'b1, 4'h0, 18'h00100, '0);
        push(1'b0, 32'h1000_AB40, cyc + 2);
        step(1'b1, 1'b0, 18'h00100, 4'h0, '0);
        idle(3);

        // Stall: read at t, clk_en=0 for t+1..t+3, rvalid rises at t+5.
        t = cyc;
        set_m0(1'b1, 4'h0, 18'h00024, '0);
        step(1'b1, 1'b0, 18'h00024, 4'h0, '0);
        set_m0(1'b0, 4'h0, '0, '0);
        set_m1(1'b1, 4'h0, 18'h00044, '0);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 4'h0, '0);
        clk_en = 1'b1;
        push(1'b0, 32'h1000_0009, t + 6);
        push(1'b1, 32'h1000_0011, t + 7);
        expect_cycle(1'b0, 1'b1, 18'h00044, 4'h0, '0);
        check("stall_rvalid_early", {63'd0, m0_rvalid}, 64'd0);
        next_cycle();
        set_m1(1'b0, 4'h0, '0, '0);
        clk_en = 1'b0;
        expect_cycle(1'b0, 1'b0, '0, 4'h0, '0);
        check("stall_rvalid_rise", {63'd0, m0_rvalid}, 64'd1);
        check("stall_rdata_rise", {32'd0, m0_rdata}, 64'h1000_0009);
        next_cycle();
        clk_en = 1'b1;
        expect_cycle(1'b0, 1'b0, '0, 4'h0, '0);
        check("stall_rvalid_hold", {63'd0, m0_rvalid}, 64'd1);
        check("stall_rdata_hold", {32'd0, m0_rdata}, 64'h1000_0009);
        next_cycle();
        idle(3);

        // Write followed immediately by a read of the same word returns the new data.
        set_m0(1'b1, 4'hF, 18'h00200, 32'h1234_5678);
        step(1'b1, 1'b0, 18'h00200, 4'hF, 32'h1234_5678);
        set_m0(1'b0, 4'h0, '0, '0);
        set_m1(1'b1, 4'h0, 18'h00200, '0);
        push(1'b1, 32'h1234_5678, cyc + 2);
        step(1'b0, 1'b1, 18'h00200, 4'h0, '0);
        idle(4);

        check("sb_drained", {32'd0, sb.size()}, 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
